// File: rtl/uart_bus_arbiter_pkg.sv
// uart_bus_arbiter_pkg: shared state encoding for the two-master UART bus arbiter.
package uart_bus_arbiter_pkg;
  localparam int ARB_STATE_W = 2;
  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY    = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_e;
endpackage

// File: rtl/uart_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; the master that did not win last time wins a tie.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: shares one UART bus slave between two masters with round-robin grant,
// a one-cycle release gap after each transaction and a watchdog error termination.
module uart_bus_arbiter
  import uart_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m0_select_i,
  input  logic              m0_we_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  input  logic              m1_select_i,
  input  logic              m1_we_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_select_o,
  output logic              s_we_o,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT - 1);

  arb_state_e    state_q;
  logic [1:0]    grant_q;
  logic          last_q;
  logic [CW-1:0] wd_cnt_q;
  logic [1:0]    gnt;
  logic          busy;
  logic          timeout;
  logic          done;
  logic          ack_ok;
  logic          err;

  rr_arbiter2 u_rr (
    .req_i  ({m1_select_i, m0_select_i}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign busy    = state_q == ARB_BUSY;
  assign timeout = busy && wd_cnt_q == WD_MAX;
  assign done    = busy && (s_ack_i || timeout);
  assign ack_ok  = busy && s_ack_i;
  assign err     = timeout && !s_ack_i;

  // grant_q is only non-zero while BUSY, so it alone gates the slave mux and master returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: if (|gnt) begin
          state_q  <= ARB_BUSY;
          grant_q  <= gnt;
          last_q   <= gnt[1];
          wd_cnt_q <= '0;
        end
        ARB_BUSY: if (done) begin
          state_q <= ARB_RELEASE;
          grant_q <= 2'b00;
        end else wd_cnt_q <= wd_cnt_q + 1'b1;
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign s_select_o = busy;
  assign busy_o     = state_q != ARB_IDLE;
  assign grant_o    = grant_q;
  assign s_addr_o   = grant_q[1] ? m1_addr_i : grant_q[0] ? m0_addr_i : '0;
  assign s_data_o   = grant_q[1] ? m1_data_i : grant_q[0] ? m0_data_i : '0;
  assign s_we_o     = grant_q[1] ? m1_we_i : grant_q[0] & m0_we_i;
  assign m0_ack_o   = grant_q[0] & done;
  assign m1_ack_o   = grant_q[1] & done;
  assign m0_err_o   = grant_q[0] & err;
  assign m1_err_o   = grant_q[1] & err;
  assign m0_data_o  = (grant_q[0] & ack_ok) ? s_data_i : '0;
  assign m1_data_o  = (grant_q[1] & ack_ok) ? s_data_i : '0;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: randomized self-checking bench against a transaction-level arbitration model.
module tb_uart_bus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o, m1_addr_i, m1_data_i, m1_data_o;
  logic        m0_select_i, m0_we_i, m0_ack_o, m0_err_o;
  logic        m1_select_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_select_o, s_we_o, s_ack_i, busy_o;
  logic [1:0]  grant_o;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] pend;
  logic       last_m;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_select_i(m0_select_i), .m0_we_i(m0_we_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_select_i(m1_select_i), .m1_we_i(m1_we_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_select_o(s_select_o), .s_we_o(s_we_o), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // Tie goes to the master that did not win last; a lone requester always wins.
  function automatic logic [1:0] pick(input logic [1:0] r, input logic l);
    return (r == 2'b11) ? (l ? 2'b01 : 2'b10) : r;
  endfunction

  task automatic step;
    @(negedge clk);
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    if (i == 0) begin
      m0_addr_i = $urandom; m0_data_i = $urandom; m0_we_i = 1'($urandom_range(0, 1));
    end else begin
      m1_addr_i = $urandom; m1_data_i = $urandom; m1_we_i = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives the slave for one granted transaction from its first BUSY cycle, then checks RELEASE.
  task automatic run_busy(input int lat, input logic [31:0] rd, input logic [1:0] g);
    int          done_k;
    bit          to_err;
    logic [31:0] ea, ed, edata;
    logic        ew;
    logic [1:0]  eack, eerr;
    done_k = lat < TO ? lat : TO;
    to_err = lat > TO;
    ea = g[1] ? m1_addr_i : m0_addr_i;
    ed = g[1] ? m1_data_i : m0_data_i;
    ew = g[1] ? m1_we_i : m0_we_i;
    for (int k = 1; k <= done_k; k++) begin
      s_ack_i  = (k == lat);
      s_data_i = (k == lat) ? rd : $urandom;
      #1;
      eack  = (k == done_k) ? g : 2'b00;
      eerr  = (k == done_k && to_err) ? g : 2'b00;
      edata = (k == done_k && !to_err) ? rd : 32'h0;
      checks++;
      if ({s_select_o, busy_o, grant_o} !== {2'b11, g}) begin
        errors++;
        $display("FAIL busy_ctl cyc=%0d got sel/busy/grant=%b exp=%b", k, {s_select_o, busy_o, grant_o}, {2'b11, g});
      end
      checks++;
      if ({s_addr_o, s_data_o, s_we_o} !== {ea, ed, ew}) begin
        errors++;
        $display("FAIL slave_mux cyc=%0d got %h/%h/%b exp %h/%h/%b", k, s_addr_o, s_data_o, s_we_o, ea, ed, ew);
      end
      checks++;
      if ({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o} !== {eack, eerr}) begin
        errors++;
        $display("FAIL ack_err cyc=%0d lat=%0d got %b exp %b", k, lat, {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, {eack, eerr});
      end
      checks++;
      if ({m1_data_o, m0_data_o} !== (g[1] ? {edata, 32'h0} : {32'h0, edata})) begin
        errors++;
        $display("FAIL rdata cyc=%0d got m1=%h m0=%h exp granted=%h other=0", k, m1_data_o, m0_data_o, edata);
      end
      step;
    end
    s_ack_i  = 1'b1;
    s_data_i = $urandom;
    #1;
    checks++;
    if ({s_select_o, busy_o, grant_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, m1_data_o, m0_data_o} !== {1'b0, 1'b1, 70'h0}) begin
      errors++;
      $display("FAIL release got sel=%b busy=%b grant=%b ack=%b%b err=%b%b exp 0/1/00/00/00",
               s_select_o, busy_o, grant_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o);
    end
    s_ack_i = 1'b0;
  endtask

  // One arbitration round from IDLE: model picks the winner, slave answers after lat cycles.
  task automatic do_round(input int lat, input logic [31:0] rd);
    logic [1:0] g;
    m0_select_i = pend[0];
    m1_select_i = pend[1];
    g = pick(pend, last_m);
    last_m = g[1];
    step;
    run_busy(lat, rd, g);
    pend &= ~g;
    m0_select_i = pend[0];
    m1_select_i = pend[1];
    step;
    #1;
    checks++;
    if ({busy_o, s_select_o, grant_o} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_gap got busy/sel/grant=%b exp 0000", {busy_o, s_select_o, grant_o});
    end
  endtask

  task automatic test_reset;
    step; step; #1;
    checks++;
    if ({s_select_o, busy_o, grant_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0", {s_select_o, busy_o, grant_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
    end
    checks++;
    if ({m0_data_o, m1_data_o, s_addr_o, s_data_o, s_we_o} !== 129'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h %b exp 0", m0_data_o, m1_data_o, s_addr_o, s_data_o, s_we_o);
    end
    rst = 1'b0;
    new_req(0);
    do_round(2, $urandom);
    new_req(0);
    m0_select_i = 1'b1;
    step; #1;
    checks++;
    if ({s_select_o, grant_o} !== 3'b101) begin
      errors++;
      $display("FAIL prereset_grant got %b exp 101", {s_select_o, grant_o});
    end
    step; step;
    #2 rst = 1'b1;
    last_m = 1'b1;
    #1;
    checks++;
    if ({s_select_o, grant_o, busy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got sel/grant/busy=%b exp 0000", {s_select_o, grant_o, busy_o});
    end
    step;
    rst = 1'b0;
    new_req(1);
    do_round(3, $urandom);
    do_round(1, $urandom);
  endtask

  task automatic test_single_write;
    new_req(0);
    m0_data_i = 32'h41;
    m0_we_i   = 1'b1;
    m0_select_i = 1'b1;
    step; #1;
    checks++;
    if ({s_select_o, s_data_o, s_we_o} !== {1'b1, 32'h41, 1'b1}) begin
      errors++;
      $display("FAIL write41 got sel=%b data=%h we=%b exp 1/41/1", s_select_o, s_data_o, s_we_o);
    end
    last_m = pick(pend, last_m) == 2'b10;
    run_busy(3, $urandom, 2'b01);
    pend = 2'b00;
    m0_select_i = 1'b0;
    step;
  endtask

  task automatic test_read_m1;
    new_req(1);
    m1_we_i = 1'b0;
    do_round($urandom_range(1, 5), 32'h5A);
  endtask

  task automatic test_back_to_back;
    new_req(0);
    new_req(1);
    for (int t = 0; t < 4; t++) begin
      do_round($urandom_range(1, 4), $urandom);
      for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
    end
    pend = 2'b00;
    m0_select_i = 1'b0;
    m1_select_i = 1'b0;
    step;
  endtask

  task automatic test_timeout;
    new_req(0);
    m0_select_i = 1'b1;
    last_m = pick(pend, last_m) == 2'b10;
    step;
    new_req(1);
    m1_select_i = 1'b1;
    run_busy(TO + 5, $urandom, 2'b01);
    pend = 2'b10;
    m0_select_i = 1'b0;
    step;
    do_round(TO, $urandom);
    new_req(1);
    do_round(TO + 1, $urandom);
    new_req(0);
    do_round(TO, $urandom);
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (pend == 2'b00) new_req($urandom_range(0, 1));
      do_round($urandom_range(1, TO + 2), $urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    {m0_addr_i, m0_data_i, m0_select_i, m0_we_i} = '0;
    {m1_addr_i, m1_data_i, m1_select_i, m1_we_i} = '0;
    s_data_i = '0;
    s_ack_i  = 1'b0;
    pend     = 2'b00;
    last_m   = 1'b1;
    test_reset;
    test_single_write;
    test_read_m1;
    test_back_to_back;
    test_timeout;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
